// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the 5-stage MIPS core.
//   hazard_t  - cause code driven by the hazard scoreboard
//   regbits_t - architectural register index (32 registers)
//   hz_thresh - countdown value above which a producer is still
//               unreadable when no forwarding network exists
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    REDIRECT = 2'd1,
    DATA     = 2'd2,
    MEMWAIT  = 2'd3
  } hazard_t;

  // With a write-before-read register file, a producer in WB (cnt = 1)
  // is already visible to the reader in ID, so only cnt > 1 stalls.
  function automatic int hz_thresh(input int rf_bypass);
    return (rf_bypass != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// sb_entry: scoreboard slot for one architectural register.
// Tracks how many pipeline advances remain before the in-flight
// producer writes the register file, and whether that producer is a load.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   adv        - pipeline advances this cycle (no freeze)
//   set        - an instruction writing this register issues this cycle
//   set_ld     - the issuing instruction is a load
//   hz         - a reader of this register in ID must stall
module sb_entry
  import cpu_types_pkg::*;
#(
  parameter int WB_DIST   = 3,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  input  logic set,
  input  logic set_ld,
  output logic hz
);

  localparam int CW  = $clog2(WB_DIST + 1);
  localparam int THR = hz_thresh(RF_BYPASS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_q, ld_d;

  // Next-state: a new issue wins over the retirement of the old producer.
  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    if (set) begin
      cnt_d = CW'(WB_DIST);
      ld_d  = set_ld;
    end else if (adv && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        ld_d = 1'b0;
      end else begin
        ld_d = ld_q;
      end
    end else begin
      cnt_d = cnt_q;
      ld_d  = ld_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  // With forwarding only a load still in EX cannot supply its result.
  always_comb begin
    if (FWD_EN != 0) begin
      hz = ld_q && (cnt_q == CW'(WB_DIST));
    end else begin
      hz = (cnt_q > CW'(THR));
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard controller for the 5-stage MIPS core.
// Keeps a per-register scoreboard of in-flight writers, freezes the pipe on
// memory waits, holds a redirect pending across a freeze and counts stalls.
// Ports:
//   CLK, nRST                  - clock, asynchronous active-low reset
//   id_valid                   - ID latch holds a real instruction
//   id_rs/id_rt, id_uses_rs/rt - source indices and read flags
//   id_wr_en, id_wsel          - destination write enable and index
//   id_is_load                 - ID instruction is a load
//   ex_redirect                - EX resolved a control transfer
//   dmem_req, dhit, ihit       - memory handshake
//   pc_enable                  - PC may advance
//   enable_ID/EX/MEM           - pipeline latch enables
//   flush_ID/EX/MEM            - pipeline latch clears
//   hazard                     - cause code
//   stall_count                - saturating count of PC-stalled cycles
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int WB_DIST   = 3,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     id_valid,
  input  logic [$clog2(NREGS)-1:0] id_rs,
  input  logic [$clog2(NREGS)-1:0] id_rt,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic                     id_wr_en,
  input  logic [$clog2(NREGS)-1:0] id_wsel,
  input  logic                     id_is_load,
  input  logic                     ex_redirect,
  input  logic                     dmem_req,
  input  logic                     dhit,
  input  logic                     ihit,
  output logic                     pc_enable,
  output logic                     enable_ID,
  output logic                     enable_EX,
  output logic                     enable_MEM,
  output logic                     flush_ID,
  output logic                     flush_EX,
  output logic                     flush_MEM,
  output hazard_t                  hazard,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int RW = $clog2(NREGS);

  logic             freeze_s;
  logic             adv_s;
  logic             redirect_now_s;
  logic             data_stall_s;
  logic             issue_s;
  logic             rs_hz_s;
  logic             rt_hz_s;
  logic [NREGS-1:0] hz_s;

  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Register 0 is hard-wired, so it never holds a producer.
  assign hz_s[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_sb
    logic set_s;
    assign set_s = issue_s && id_wr_en && (id_wsel == RW'(r));
    sb_entry #(
      .WB_DIST   (WB_DIST),
      .FWD_EN    (FWD_EN),
      .RF_BYPASS (RF_BYPASS)
    ) u_entry (
      .clk    (CLK),
      .rst_n  (nRST),
      .adv    (adv_s),
      .set    (set_s),
      .set_ld (id_is_load),
      .hz     (hz_s[r])
    );
  end

  // Freeze, redirect, data-stall and issue conditions.
  always_comb begin
    freeze_s       = (dmem_req && !dhit) || !ihit;
    adv_s          = !freeze_s;
    redirect_now_s = !freeze_s && (ex_redirect || redir_pend_q);
    rs_hz_s        = id_uses_rs && (id_rs != '0) && hz_s[id_rs];
    rt_hz_s        = id_uses_rt && (id_rt != '0) && hz_s[id_rt];
    data_stall_s   = id_valid && (rs_hz_s || rt_hz_s);
    issue_s        = adv_s && id_valid && !data_stall_s && !redirect_now_s;
  end

  // Output decode in priority order: freeze, redirect, data stall, run.
  always_comb begin
    pc_enable  = 1'b1;
    enable_ID  = 1'b1;
    enable_EX  = 1'b1;
    enable_MEM = 1'b1;
    flush_ID   = 1'b0;
    flush_EX   = 1'b0;
    flush_MEM  = 1'b0;
    hazard     = NONE;
    if (freeze_s) begin
      pc_enable  = 1'b0;
      enable_ID  = 1'b0;
      enable_EX  = 1'b0;
      enable_MEM = 1'b0;
      hazard     = MEMWAIT;
    end else if (redirect_now_s) begin
      flush_ID = 1'b1;
      flush_EX = 1'b1;
      hazard   = REDIRECT;
    end else if (data_stall_s) begin
      pc_enable = 1'b0;
      enable_ID = 1'b0;
      flush_EX  = 1'b1;
      hazard    = DATA;
    end else begin
      hazard = NONE;
    end
  end

  // A redirect seen during a freeze is remembered until it can be applied.
  always_comb begin
    if (redirect_now_s) begin
      redir_pend_d = 1'b0;
    end else if (freeze_s && ex_redirect) begin
      redir_pend_d = 1'b1;
    end else begin
      redir_pend_d = redir_pend_q;
    end
  end

  // Stall counter saturates at all-ones.
  always_comb begin
    if (!pc_enable && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      redir_pend_q  <= 1'b0;
      stall_count_q <= '0;
    end else begin
      redir_pend_q  <= redir_pend_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
